// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants and the nibble-to-segment decode.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Letters A..F collapse to blank when hex display is disabled.
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib, input logic hex_mode);
        logic [6:0] s;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: s = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: s = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: s = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: s = hex_mode ? SEG_E : SEG_BLANK;
            default: s = hex_mode ? SEG_F : SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg_decode
    import sevenseg_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = nibble_to_seg(nib, HEX_MODE != 0);

endmodule

// File: rtl/sevenseg_mux_display.sv
// Time-multiplexed seven-segment driver with double-buffered value,
// per-slot anti-ghost blanking and optional leading-zero suppression.
module sevenseg_mux_display
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HEX_MODE     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          slot_cnt_reg;
    logic [IDX_W-1:0]          index_reg;
    logic [4*NUM_DIGITS-1:0]   shadow_val_reg;
    logic [NUM_DIGITS-1:0]     shadow_dp_reg;
    logic [4*NUM_DIGITS-1:0]   active_val_reg;
    logic [NUM_DIGITS-1:0]     active_dp_reg;
    logic                      pending_reg;
    logic [6:0]                seg_reg;
    logic                      dp_reg;
    logic [NUM_DIGITS-1:0]     an_reg;

    logic [6:0]                seg_next;
    logic                      dp_next;
    logic [NUM_DIGITS-1:0]     an_next;
    logic [CNT_W-1:0]          slot_cnt_next;
    logic [IDX_W-1:0]          index_next;

    logic                      slot_wrap;
    logic                      frame_boundary;
    logic                      blanking;
    logic [3:0]                nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     lz_blank;
    logic [NUM_DIGITS-1:0]     an_sel;
    logic [6:0]                seg_dec;

    assign slot_wrap      = (slot_cnt_reg == SLOT_LAST);
    assign frame_boundary = slot_wrap && (index_reg == IDX_LAST);
    assign blanking       = int'(slot_cnt_reg) < BLANK_CYCLES;

    // lz_blank[i]: every active nibble from i upward is zero (digit 0 exempt).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = active_val_reg[4*gi +: 4];
            assign an_sel[gi]  = (index_reg != IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = (active_val_reg[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    seg_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_seg_decode (
        .nib (nib_arr[index_reg]),
        .seg (seg_dec)
    );

    always_comb begin
        slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + CNT_W'(1);
        index_next    = index_reg;
        if (slot_wrap) begin
            index_next = (index_reg == IDX_LAST) ? '0 : index_reg + IDX_W'(1);
        end

        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        an_next  = '1;
        if (!blanking) begin
            an_next = an_sel;
            dp_next = ~active_dp_reg[index_reg];
            if (!(lz_suppress && lz_blank[index_reg])) begin
                seg_next = seg_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_reg   <= '0;
            index_reg      <= '0;
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            active_val_reg <= '0;
            active_dp_reg  <= '0;
            pending_reg    <= 1'b0;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
        end else begin
            slot_cnt_reg <= slot_cnt_next;
            index_reg    <= index_next;
            seg_reg      <= seg_next;
            dp_reg       <= dp_next;
            an_reg       <= an_next;
            // A load landing on the boundary bypasses the shadow so the
            // new frame already shows it.
            if (load && frame_boundary) begin
                active_val_reg <= value;
                active_dp_reg  <= dp_in;
                pending_reg    <= 1'b0;
            end else if (load) begin
                shadow_val_reg <= value;
                shadow_dp_reg  <= dp_in;
                pending_reg    <= 1'b1;
            end else if (frame_boundary && pending_reg) begin
                active_val_reg <= shadow_val_reg;
                active_dp_reg  <= shadow_dp_reg;
                pending_reg    <= 1'b0;
            end
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule
